// File: rtl/uart_arb_pkg.sv
// Shared FSM state type and default parameters for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int DEFAULT_N_REQ     = 4;
  localparam int DEFAULT_MAX_BURST = 16;
  localparam int DEFAULT_START_TO  = 8;
  localparam int DEFAULT_LOCK_TO   = 255;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr_i+1 (mod N_REQ) wins.
// Zero latency; with no request set, gnt_o is all zero and idx_o is zero.
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int IW = $clog2(N_REQ);

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr_i) + k) % N_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte streams, with frame locking.
// Accept-to-tx_enable is one cycle; no req_ready is given while the transmitter is owned or busy.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = DEFAULT_N_REQ,
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int START_TO  = DEFAULT_START_TO,
  parameter int LOCK_TO   = DEFAULT_LOCK_TO
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*8-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [7:0]               tx_byte,
  output logic                     tx_enable,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     locked,
  output logic                     tx_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(START_TO + 1);
  localparam int TW = $clog2(LOCK_TO + 1);

  arb_state_e    state_q, state_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          locked_q, locked_d;
  logic [BW-1:0] burst_q, burst_d, burst_inc;
  logic [SW-1:0] start_q, start_d;
  logic [TW-1:0] idle_q, idle_d;

  logic [N_REQ-1:0] elig, pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             accept, start_expired;

  // A locked frame restricts eligibility to its owner; the pointer is simply the last grant.
  always_comb begin
    elig = req_valid;
    if (locked_q) begin
      elig           = '0;
      elig[grant_q]  = req_valid[grant_q];
    end
  end

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req_i (elig),
    .ptr_i (grant_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign accept        = (state_q == IDLE) && !tx_busy && (|elig);
  assign burst_inc     = locked_q ? burst_q + 1'b1 : BW'(1);
  assign start_expired = (start_q == SW'(START_TO - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_byte_q <= '0;
      grant_q   <= IW'(N_REQ - 1);
      locked_q  <= 1'b0;
      burst_q   <= '0;
      start_q   <= '0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      grant_q   <= grant_d;
      locked_q  <= locked_d;
      burst_q   <= burst_d;
      start_q   <= start_d;
      idle_q    <= idle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    grant_d   = grant_q;
    locked_d  = locked_q;
    burst_d   = burst_q;
    start_d   = start_q;
    idle_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ISSUE;
          tx_byte_d = req_data[{pick_idx, 3'b000} +: 8];
          grant_d   = pick_idx;
          if (req_last[pick_idx] || burst_inc == BW'(MAX_BURST)) begin
            locked_d = 1'b0;
            burst_d  = '0;
          end else begin
            locked_d = 1'b1;
            burst_d  = burst_inc;
          end
        end else if (locked_q && !req_valid[grant_q]) begin
          // Owner has gone quiet: drop the lock after LOCK_TO consecutive idle cycles.
          if (idle_q == TW'(LOCK_TO - 1)) begin
            locked_d = 1'b0;
            burst_d  = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        start_d = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy)            state_d = WAIT_DONE;
        else if (start_expired) state_d = IDLE;
        else                    start_d = start_q + 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept && !reset) req_ready = pick_gnt;
    tx_enable = (state_q == ISSUE);
    tx_err    = (state_q == WAIT_BUSY) && !tx_busy && start_expired;
  end

  assign tx_byte  = tx_byte_q;
  assign grant_id = grant_q;
  assign locked   = locked_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters: N_REQ, default 4, number of requesters; MAX_BURST, default 16, max bytes per locked frame; START_TO, default 8, cycles allowed for tx_busy to rise; LOCK_TO, default 255, idle cycles before a lock is dropped.
REQ-002 Ports, one per line: name, direction, width, meaning.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  N_REQ  per-requester byte available.
REQ-006 req_data  in  N_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 req_last  in  N_REQ  byte is the final byte of its frame.
REQ-008 req_ready  out  N_REQ  one-cycle accept strobe; a byte transfers when valid and ready are both high.
REQ-009 tx_byte  out  8  byte presented to the shared UART transmitter.
REQ-010 tx_enable  out  1  one-cycle start pulse to the transmitter.
REQ-011 tx_busy  in  1  transmitter busy flag.
REQ-012 grant_id  out  $clog2(N_REQ)  requester currently owning the transmitter.
REQ-013 locked  out  1  a multi-byte frame is in progress.
REQ-014 tx_err  out  1  one-cycle pulse when tx_busy fails to rise within START_TO cycles.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-016 In IDLE with tx_busy=0 and at least one eligible req_valid: req_ready[winner]=1 combinationally in that cycle; req_data[winner] is registered into tx_byte; grant_id<=winner; next state ISSUE.
REQ-017 Eligibility when unlocked: all requesters, round-robin, highest priority at (last grant + 1) mod N_REQ. When locked: only grant_id.
REQ-018 In IDLE with tx_busy=1: no grant and no req_ready until tx_busy=0.
REQ-019 In ISSUE: tx_enable=1 for exactly one cycle with tx_byte stable; next state WAIT_BUSY.
REQ-020 In WAIT_BUSY: tx_busy=1 moves to WAIT_DONE. If START_TO cycles pass without tx_busy, pulse tx_err for one cycle and go to IDLE; the byte counts as sent.
REQ-021 In WAIT_DONE: tx_busy=0 moves to IDLE; tx_byte holds its value until the next accept.
REQ-022 Lock rule: an accepted byte with req_last=0 sets locked=1. An accepted byte with req_last=1 clears locked.
REQ-023 Burst counter (width $clog2(MAX_BURST+1)): counts accepted bytes while locked. When it reaches MAX_BURST, locked clears after that byte regardless of req_last, and the pointer advances normally.
REQ-024 Lock timeout: while locked in IDLE with req_valid[grant_id]=0 for LOCK_TO consecutive cycles, locked clears and arbitration reopens in the next cycle.
REQ-025 Round-robin pointer updates only on an unlocked-to-new grant; locked continuation bytes do not move it.
REQ-026 Worst-case latency from accept to tx_enable is 1 cycle; minimum accept-to-accept spacing is 4 cycles plus tx_busy duration.
REQ-027 Simultaneous events: req_valid deasserted in the cycle after req_ready has no effect, because the byte is already captured. A new req_valid arriving in the same cycle as lock release competes normally.

Reset
REQ-028 While reset=1: state=IDLE; tx_byte=0; tx_enable=0; req_ready=0; grant_id=N_REQ-1, so requester 0 has first priority; locked=0; tx_err=0; all counters=0.
REQ-029 Reset asserted mid-transfer aborts immediately with no tx_enable pulse afterward. A transmitter already started is not waited for; after release, REQ-018 governs.

Structure
REQ-030 Shared package uart_arb_pkg holds the FSM state enum and default parameter constants (MAX_BURST, START_TO, LOCK_TO).
REQ-031 Sub-module rr_picker, purely combinational: inputs request mask and pointer, outputs one-hot grant and index. It is instantiated once.

Verification
REQ-032 Single requester: req_valid[2]=1, data 0x55, last=1 -> req_ready[2] pulse, tx_enable 1 cycle later with tx_byte=0x55, grant_id=2.
REQ-033 All four valid continuously, last=1 after reset -> grant order 0,1,2,3,0, one byte each, each after tx_busy falls.
REQ-034 Requester 1 sends a 3-byte frame (last on byte 3) while requester 0 is valid -> bytes 1a,1b,1c contiguous and locked=1 until 1c, then requester 2 or 0 per pointer.
REQ-035 Frame longer than MAX_BURST=16 with last never set -> lock drops after byte 16 and another valid requester wins next.
REQ-036 tx_busy tied low -> tx_err pulses 8 cycles after tx_enable and FSM returns to IDLE; tx_busy held high at grant time -> no req_ready.
REQ-037 Reset asserted in WAIT_DONE -> all outputs reach REQ-028 values asynchronously; first post-reset grant goes to requester 0.
